// File: rtl/alu_control_mdu.sv
// RV32 ALU control decode plus optional iterative RV32M unit (ALU_CTRL_MDU_EN). Results appear one
// cycle after acceptance, or XLEN+2 cycles for iterative M ops; in_ready is low until out_ready takes the result.
module alu_control_mdu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] OpA,
   input  logic [XLEN-1:0] OpB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      ALUControlInput,
   output logic [XLEN-1:0] MulDivResult,
   output logic            is_muldiv,
   output logic            illegal
);
   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef ALU_CTRL_MDU_EN
      S_MUL, S_DIV, S_FIX,
`endif
      S_DONE
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_ctrl, w_ctrl, w_base;
   logic       r_ill, w_ill, w_md, w_accept;

   always_comb begin
      case (Funct3)
         3'b000:  w_base = 4'b0010;
         3'b001:  w_base = 4'b0100;
         3'b010:  w_base = 4'b1000;
         3'b011:  w_base = 4'b1001;
         3'b100:  w_base = 4'b0011;
         3'b101:  w_base = 4'b0101;
         3'b110:  w_base = 4'b0001;
         default: w_base = 4'b0000;
      endcase
      w_ctrl = 4'b1111;
      w_md   = 1'b0;
      case (ALUOp)
         2'b00: w_ctrl = 4'b0010;
         2'b01: w_ctrl = 4'b0110;
         2'b10: begin
            if (Funct7 == 7'b0000000) w_ctrl = w_base;
            else if (Funct7 == 7'b0100000 && Funct3 == 3'b000) w_ctrl = 4'b0110;
            else if (Funct7 == 7'b0100000 && Funct3 == 3'b101) w_ctrl = 4'b0111;
`ifdef ALU_CTRL_MDU_EN
            else if (Funct7 == 7'b0000001) begin
               w_ctrl = 4'b1010;
               w_md   = 1'b1;
            end
`endif
         end
         default: begin
            // only the immediate shifts constrain imm[11:5]
            if (Funct3 != 3'b001 && Funct3 != 3'b101) w_ctrl = w_base;
            else if (Funct7 == 7'b0000000) w_ctrl = w_base;
            else if (Funct3 == 3'b101 && Funct7 == 7'b0100000) w_ctrl = 4'b0111;
         end
      endcase
   end

   assign w_ill    = (w_ctrl == 4'b1111);
   assign w_accept = in_valid && in_ready;

`ifdef ALU_CTRL_MDU_EN
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi, r_lo, r_b, r_res, w_a_mag, w_b_mag, w_spec_res, w_fix;
   logic [2:0]        r_f3;
   logic              r_neg, r_is_md;
   logic              w_a_neg, w_b_neg, w_b_zero, w_ovf, w_spec;
   logic [XLEN:0]     w_add, w_sub;
   logic [2*XLEN-1:0] w_prod;

   assign w_a_neg    = OpA[XLEN-1] && (Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
   assign w_b_neg    = OpB[XLEN-1] && (Funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
   assign w_a_mag    = w_a_neg ? -OpA : OpA;
   assign w_b_mag    = w_b_neg ? -OpB : OpB;
   assign w_b_zero   = (OpB == '0);
   assign w_ovf      = !Funct3[0] && (OpA == {1'b1, {(XLEN-1){1'b0}}}) && (&OpB);
   assign w_spec     = Funct3[2] && (w_b_zero || w_ovf);
   assign w_spec_res = w_b_zero ? (Funct3[1] ? OpA : '1) : (Funct3[1] ? '0 : OpA);

   // r_hi/r_lo hold {product} while multiplying and {remainder, quotient} while dividing
   assign w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_sub  = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};
   assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
   assign w_fix  = !r_f3[2] ? ((r_f3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                 : r_f3[1]  ? (r_neg ? -r_hi : r_hi) : (r_neg ? -r_lo : r_lo);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_f3    <= '0;
         r_neg   <= 1'b0;
         r_is_md <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_cnt   <= '0;
               r_hi    <= '0;
               r_lo    <= w_a_mag;
               r_b     <= w_b_mag;
               r_f3    <= Funct3;
               r_neg   <= (Funct3[2] && Funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
               r_is_md <= w_md;
               r_res   <= (w_md && w_spec) ? w_spec_res : '0;
            end
            S_MUL: begin
               {r_hi, r_lo} <= {w_add, r_lo[XLEN-1:1]};
               r_cnt        <= r_cnt + CW'(1);
            end
            S_DIV: begin
               r_hi  <= w_sub[XLEN] ? {r_hi[XLEN-2:0], r_lo[XLEN-1]} : w_sub[XLEN-1:0];
               r_lo  <= {r_lo[XLEN-2:0], ~w_sub[XLEN]};
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX:   r_res <= w_fix;
            default: ;
         endcase
      end
   end

   assign MulDivResult = r_res;
   assign is_muldiv    = r_is_md;
`else
   logic w_unused;
   assign w_unused     = ^{OpA, OpB, w_md};
   assign MulDivResult = '0;
   assign is_muldiv    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = S_DONE;
`ifdef ALU_CTRL_MDU_EN
               if (w_md && !w_spec) w_state_nxt = Funct3[2] ? S_DIV : S_MUL;
`endif
            end
         end
`ifdef ALU_CTRL_MDU_EN
         S_MUL, S_DIV: if (r_cnt == CW'(XLEN-1)) w_state_nxt = S_FIX;
         S_FIX:        w_state_nxt = S_DONE;
`endif
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl <= '0;
         r_ill  <= 1'b0;
      end else if (w_accept) begin
         r_ctrl <= w_ctrl;
         r_ill  <= w_ill;
      end
   end

   assign ALUControlInput = r_ctrl;
   assign illegal         = r_ill;
endmodule

// File: tb/tb_alu_control_mdu.sv
// Randomized and directed bench for alu_control_mdu against an arithmetic reference model.
module tb_alu_control_mdu;
`ifdef ALU_CTRL_MDU_EN
   localparam bit MDU = 1'b1;
`else
   localparam bit MDU = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, is_muldiv, illegal;
   logic [1:0]  ALUOp = '0;
   logic [6:0]  Funct7 = '0;
   logic [2:0]  Funct3 = '0;
   logic [31:0] OpA = '0, OpB = '0, MulDivResult;
   logic [3:0]  ALUControlInput;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   alu_control_mdu #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUOp(ALUOp),
      .Funct7(Funct7), .Funct3(Funct3), .OpA(OpA), .OpB(OpB), .out_valid(out_valid),
      .out_ready(out_ready), .ALUControlInput(ALUControlInput), .MulDivResult(MulDivResult),
      .is_muldiv(is_muldiv), .illegal(illegal));

   logic [3:0] base_code [8] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};

   function automatic void model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [3:0] ctrl, output logic ill, output logic md,
                                 output logic [31:0] res, output int lat);
      logic signed [63:0] sa, sb, ua, ub, p;
      logic signed [31:0] a32, b32;
      sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; ua = {32'b0, a}; ub = {32'b0, b};
      a32 = a; b32 = b;
      ctrl = 4'hF; md = 1'b0; res = '0; lat = 1; p = '0;
      if (op == 2'd0) ctrl = 4'h2;
      else if (op == 2'd1) ctrl = 4'h6;
      else if (op == 2'd2 && f7 == 7'h00) ctrl = base_code[f3];
      else if (op == 2'd2 && f7 == 7'h20 && f3 == 3'd0) ctrl = 4'h6;
      else if (op == 2'd2 && f7 == 7'h20 && f3 == 3'd5) ctrl = 4'h7;
      else if (op == 2'd3 && f3 != 3'd1 && f3 != 3'd5) ctrl = base_code[f3];
      else if (op == 2'd3 && f7 == 7'h00) ctrl = base_code[f3];
      else if (op == 2'd3 && f3 == 3'd5 && f7 == 7'h20) ctrl = 4'h7;
      else if (MDU && op == 2'd2 && f7 == 7'h01) begin
         ctrl = 4'hA; md = 1'b1; lat = 34;
         case (f3)
            3'd0: begin p = sa * sb; res = p[31:0]; end
            3'd1: begin p = sa * sb; res = p[63:32]; end
            3'd2: begin p = sa * ub; res = p[63:32]; end
            3'd3: begin p = ua * ub; res = p[63:32]; end
            3'd4: if (b == 0) begin res = '1; lat = 1; end
                  else if (a == 32'h8000_0000 && b == '1) begin res = a; lat = 1; end
                  else res = a32 / b32;
            3'd5: if (b == 0) begin res = '1; lat = 1; end else res = a / b;
            3'd6: if (b == 0) begin res = a; lat = 1; end
                  else if (a == 32'h8000_0000 && b == '1) begin res = '0; lat = 1; end
                  else res = a32 % b32;
            default: if (b == 0) begin res = a; lat = 1; end else res = a % b;
         endcase
      end
      ill = (ctrl == 4'hF);
   endfunction

   // Drives one request, scrambles inputs while busy, returns cycles to out_valid (-1 on timeout).
   task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      in_valid = 1'b1; ALUOp = op; Funct7 = f7; Funct3 = f3; OpA = a; OpB = b;
      @(posedge clk);
      lat = 1;
      #1;
      ALUOp = 2'($urandom); Funct7 = 7'($urandom); Funct3 = 3'($urandom);
      OpA = $urandom; OpB = $urandom;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         #1;
      end
      in_valid = 1'b0;
      if (!out_valid) lat = -1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks += 6;
      if (in_ready !== 1'b1)        begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
      if (out_valid !== 1'b0)       begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      if (ALUControlInput !== 4'h0) begin errors++; $display("FAIL reset ctrl got %h want 0", ALUControlInput); end
      if (MulDivResult !== 32'h0)   begin errors++; $display("FAIL reset result got %h want 0", MulDivResult); end
      if (is_muldiv !== 1'b0)       begin errors++; $display("FAIL reset is_muldiv got %b want 0", is_muldiv); end
      if (illegal !== 1'b0)         begin errors++; $display("FAIL reset illegal got %b want 0", illegal); end
   endtask

   logic [1:0] d_op  [10] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
   logic [6:0] d_f7  [10] = '{7'h20, 7'h20, 7'h20, 7'h20, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h55, 7'h20};
   logic [2:0] d_f3  [10] = '{3'd0, 3'd0, 3'd5, 3'd1, 3'd2, 3'd7, 3'd3, 3'd0, 3'd3, 3'd1};
   logic [3:0] d_exp [10] = '{4'h6, 4'h2, 4'h7, 4'hF, 4'h8, 4'h2, 4'h6, 4'hF, 4'h9, 4'hF};

   task automatic test_decode_directed();
      int lat;
      for (int i = 0; i < 10; i++) begin
         run_op(d_op[i], d_f7[i], d_f3[i], $urandom, $urandom, lat);
         checks += 4;
         if (ALUControlInput !== d_exp[i]) begin errors++; $display("FAIL dec%0d ctrl got %h want %h", i, ALUControlInput, d_exp[i]); end
         if (illegal !== (d_exp[i] == 4'hF)) begin errors++; $display("FAIL dec%0d illegal got %b", i, illegal); end
         if (lat !== 1)                    begin errors++; $display("FAIL dec%0d latency got %0d want 1", i, lat); end
         if (MulDivResult !== 32'h0 || is_muldiv !== 1'b0) begin
            errors++; $display("FAIL dec%0d mdu outputs got %h/%b want 0/0", i, MulDivResult, is_muldiv);
         end
         step();
      end
   endtask

   logic [2:0]  m_f3  [9] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
   logic [31:0] m_a   [9] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5};
   logic [31:0] m_b   [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd2, 32'd2, 32'd0, 32'd0};
   logic [31:0] m_res [9] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'h80000000, 32'h0,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
   int          m_lat [9] = '{34, 34, 34, 1, 1, 34, 34, 1, 1};

   task automatic test_muldiv_directed();
      int lat;
      logic [31:0] want;
      int wlat;
      for (int i = 0; i < 9; i++) begin
         run_op(2'd2, 7'h01, m_f3[i], m_a[i], m_b[i], lat);
         want = MDU ? m_res[i] : 32'h0;
         wlat = MDU ? m_lat[i] : 1;
         checks += 4;
         if (MulDivResult !== want) begin errors++; $display("FAIL mdu%0d result got %h want %h", i, MulDivResult, want); end
         if (lat !== wlat)          begin errors++; $display("FAIL mdu%0d latency got %0d want %0d", i, lat, wlat); end
         if (ALUControlInput !== (MDU ? 4'hA : 4'hF) || illegal !== !MDU) begin
            errors++; $display("FAIL mdu%0d ctrl/illegal got %h/%b", i, ALUControlInput, illegal);
         end
         if (is_muldiv !== MDU) begin errors++; $display("FAIL mdu%0d is_muldiv got %b want %b", i, is_muldiv, MDU); end
         step();
      end
   endtask

   task automatic test_random(input int n, input bit mdu_only);
      int lat, wlat;
      logic [1:0] op; logic [6:0] f7; logic [2:0] f3; logic [31:0] a, b, wres;
      logic [3:0] wctrl; logic wil, wmd;
      for (int i = 0; i < n; i++) begin
         op = mdu_only ? 2'd2 : 2'($urandom);
         case ($urandom_range(3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         if (mdu_only) f7 = 7'h01;
         f3 = 3'($urandom);
         a = $urandom; b = $urandom;
         case ($urandom_range(7))
            0: b = 32'h0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(15));
            default: ;
         endcase
         model(op, f7, f3, a, b, wctrl, wil, wmd, wres, wlat);
         run_op(op, f7, f3, a, b, lat);
         checks += 5;
         if (ALUControlInput !== wctrl) begin errors++; $display("FAIL rnd%0d ctrl op%0d f7 %h f3 %0d got %h want %h", i, op, f7, f3, ALUControlInput, wctrl); end
         if (illegal !== wil)           begin errors++; $display("FAIL rnd%0d illegal got %b want %b", i, illegal, wil); end
         if (is_muldiv !== wmd)         begin errors++; $display("FAIL rnd%0d is_muldiv got %b want %b", i, is_muldiv, wmd); end
         if (MulDivResult !== wres)     begin errors++; $display("FAIL rnd%0d result f3 %0d a %h b %h got %h want %h", i, f3, a, b, MulDivResult, wres); end
         if (lat !== wlat)              begin errors++; $display("FAIL rnd%0d latency got %0d want %0d", i, lat, wlat); end
         step();
      end
   endtask

   task automatic test_hold();
      int lat, wlat;
      logic [31:0] a, b, wres;
      logic [3:0] wctrl; logic wil, wmd;
      a = $urandom; b = $urandom | 32'h1;
      model(2'd2, 7'h01, 3'd1, a, b, wctrl, wil, wmd, wres, wlat);
      out_ready = 1'b0;
      run_op(2'd2, 7'h01, 3'd1, a, b, lat);
      for (int c = 0; c < 3; c++) begin
         step();
         checks += 3;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold%0d valid/ready got %b/%b want 1/0", c, out_valid, in_ready);
         end
         if (MulDivResult !== wres) begin errors++; $display("FAIL hold%0d result got %h want %h", c, MulDivResult, wres); end
         if (ALUControlInput !== wctrl || illegal !== wil || is_muldiv !== wmd) begin
            errors++; $display("FAIL hold%0d ctrl got %h want %h", c, ALUControlInput, wctrl);
         end
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL release valid/ready got %b/%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_valid = 1'b1; ALUOp = 2'd2; Funct7 = 7'h00; Funct3 = 3'd4; OpA = $urandom; OpB = $urandom;
      step();
      checks += 4;
      if (out_valid !== 1'b1 || ALUControlInput !== 4'h3) begin
         errors++; $display("FAIL b2b first got valid %b ctrl %h want 1/3", out_valid, ALUControlInput);
      end
      ALUOp = 2'd3; Funct7 = 7'h20; Funct3 = 3'd5;
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b gap valid/ready got %b/%b want 0/1", out_valid, in_ready);
      end
      step();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || ALUControlInput !== 4'h7) begin
         errors++; $display("FAIL b2b second got valid %b ctrl %h want 1/7", out_valid, ALUControlInput);
      end
      step();
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b queued got valid %b want 0", out_valid); end
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      @(negedge clk);
      in_valid = 1'b1; ALUOp = 2'd2; Funct7 = 7'h01; Funct3 = 3'd5; OpA = $urandom; OpB = $urandom | 32'h1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      step();
      checks += 3;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL abort valid/ready got %b/%b want 0/1", out_valid, in_ready);
      end
      if (MulDivResult !== 32'h0 || is_muldiv !== 1'b0) begin
         errors++; $display("FAIL abort outputs got %h/%b want 0/0", MulDivResult, is_muldiv);
      end
      rst = 1'b0;
      repeat (40) begin
         step();
         if (out_valid) seen++;
      end
      if (seen !== 0) begin errors++; $display("FAIL abort emitted %0d result cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_decode_directed();
      test_muldiv_directed();
      test_random(60, 1'b0);
      test_random(30, 1'b1);
      test_hold();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
